// File: rtl/lut_shift_seq_if.sv
// rtl/lut_shift_seq_if.sv - START/ABORT control and shift-step handshake bundle
// Purpose: groups the request, valid/ready step stream and status flags of lut_shift_seq.
// Ports (signals):
//   START, ABORT   requester -> generator, one-cycle request / synchronous cancel
//   READY          datapath  -> generator, step accepted
//   VALID, SHIFT, ADRS, LAST   generator -> datapath, current iteration step
//   BUSY, DONE     generator -> requester, status and end-of-sequence pulse
// Modports: master = LN control FSM + CORDIC datapath side, slave = generator.
interface lut_shift_seq_if #(
  parameter int SHIFT_WIDTH = 5
);
  logic                   START;
  logic                   ABORT;
  logic                   READY;
  logic                   VALID;
  logic [SHIFT_WIDTH-1:0] SHIFT;
  logic [SHIFT_WIDTH-1:0] ADRS;
  logic                   LAST;
  logic                   BUSY;
  logic                   DONE;

  modport master (
    output START, ABORT, READY,
    input  VALID, SHIFT, ADRS, LAST, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, READY,
    output VALID, SHIFT, ADRS, LAST, BUSY, DONE
  );
endinterface

// File: rtl/lut_shift_seq.sv
// rtl/lut_shift_seq.sv - self-sequencing hyperbolic CORDIC shift/atanh-address generator
// Purpose: after START, emits NUM_STEPS shift amounts starting at FIRST_SHIFT, repeating
//   REPEAT_A and REPEAT_B (0 disables B) once each, over a valid/ready handshake.
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   asynchronous active-low reset
//   bus    slave modport of lut_shift_seq_if (START/ABORT/READY in,
//          VALID/SHIFT/ADRS/LAST/BUSY/DONE out, all outputs registered)
module lut_shift_seq #(
  parameter int SHIFT_WIDTH = 5,
  parameter int NUM_STEPS   = 26,
  parameter int FIRST_SHIFT = 1,
  parameter int REPEAT_A    = 4,
  parameter int REPEAT_B    = 13
) (
  input  logic             CLK,
  input  logic             RST_N,
  lut_shift_seq_if.slave   bus
);

  if (FIRST_SHIFT + NUM_STEPS >= (1 << SHIFT_WIDTH)) begin : g_bad_width
    $error("lut_shift_seq: FIRST_SHIFT+NUM_STEPS must be below 2**SHIFT_WIDTH");
  end
  if (NUM_STEPS < 1) begin : g_bad_steps
    $error("lut_shift_seq: NUM_STEPS must be at least 1");
  end

  localparam logic [SHIFT_WIDTH-1:0] C_FIRST     = SHIFT_WIDTH'(FIRST_SHIFT);
  localparam logic [SHIFT_WIDTH-1:0] C_REP_A     = SHIFT_WIDTH'(REPEAT_A);
  localparam logic [SHIFT_WIDTH-1:0] C_REP_B     = SHIFT_WIDTH'(REPEAT_B);
  localparam logic [SHIFT_WIDTH-1:0] C_LAST_STEP = SHIFT_WIDTH'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SHIFT_WIDTH-1:0] r_step;
  logic                   r_rep;
  logic                   r_valid;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [SHIFT_WIDTH-1:0] r_adrs;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_xfer;
  logic                   w_hold_shift;
  logic [SHIFT_WIDTH-1:0] w_step_nxt;

  // r_valid is only ever set in RUN, so it alone qualifies a transfer.
  assign w_xfer     = r_valid & bus.READY;
  assign w_step_nxt = r_step + 1'b1;
  // First copy of a repeated shift: keep SHIFT and mark the repeat as consumed.
  // REPEAT_B of zero never matches because shift values start at FIRST_SHIFT >= 1.
  assign w_hold_shift = !r_rep &&
                        ((r_shift == C_REP_A) || ((C_REP_B != '0) && (r_shift == C_REP_B)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_rep   <= 1'b0;
      r_valid <= 1'b0;
      r_shift <= '0;
      r_adrs  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.ABORT) begin
      // SHIFT/ADRS are left as-is; VALID=0 marks them stale.
      r_state <= S_IDLE;
      r_step  <= '0;
      r_rep   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.START) begin
            r_state <= S_RUN;
            r_step  <= '0;
            r_rep   <= 1'b0;
            r_valid <= 1'b1;
            r_shift <= C_FIRST;
            r_adrs  <= C_FIRST - 1'b1;
            r_last  <= (C_LAST_STEP == '0);
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step <= w_step_nxt;
              r_last <= (w_step_nxt == C_LAST_STEP);
              if (w_hold_shift) begin
                r_rep <= 1'b1;
              end else begin
                r_rep   <= 1'b0;
                r_shift <= r_shift + 1'b1;
                r_adrs  <= r_shift;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_step  <= '0;
          r_rep   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.VALID = r_valid;
  assign bus.SHIFT = r_shift;
  assign bus.ADRS  = r_adrs;
  assign bus.LAST  = r_last;
  assign bus.BUSY  = r_busy;
  assign bus.DONE  = r_done;

endmodule

// File: tb/tb_lut_shift_seq.sv
// tb/tb_lut_shift_seq.sv - scoreboard bench for lut_shift_seq (default and short/no-REPEAT_B builds)
module tb_lut_shift_seq;

  typedef struct packed {
    logic [4:0] shift;
    logic [4:0] adrs;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;

  lut_shift_seq_if #(.SHIFT_WIDTH(5)) bus ();
  lut_shift_seq_if #(.SHIFT_WIDTH(5)) bus2 ();

  lut_shift_seq dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  lut_shift_seq #(
    .SHIFT_WIDTH (5),
    .NUM_STEPS   (6),
    .FIRST_SHIFT (1),
    .REPEAT_A    (4),
    .REPEAT_B    (0)
  ) dut2 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t sb[$];
  beat_t sb2[$];
  int    beats      = 0;
  int    beats2     = 0;
  int    done_cnt   = 0;
  int    done_cnt2  = 0;
  bit    done_exp   = 0;
  bit    stall_pend = 0;
  beat_t stall_val;

  // Hand-written default sequence: 1..24 with 4 and 13 emitted twice.
  int full_seq [26] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13,
                        14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24};
  int short_seq [6] = '{1, 2, 3, 4, 4, 5};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic beat_t mk(input int s, input bit l);
    beat_t b;
    b.shift = 5'(s);
    b.adrs  = 5'(s - 1);
    b.last  = l;
    return b;
  endfunction

  // Monitor for the default build: pops on each transfer, checks stall stability and DONE timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_exp) begin
        chk("done_after_last", 32'(bus.DONE), 32'd1);
        done_exp = 0;
      end
      if (bus.DONE) done_cnt++;
      if (stall_pend) begin
        chk("stall_valid_hold", 32'(bus.VALID), 32'd1);
        chk("stall_beat_hold", 32'({bus.SHIFT, bus.ADRS, bus.LAST}), 32'(stall_val));
        stall_pend = 0;
      end
      if (bus.VALID && bus.READY) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'({bus.SHIFT, bus.ADRS, bus.LAST}), 32'h7ff);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_shift", 32'(bus.SHIFT), 32'(e.shift));
          chk("beat_adrs", 32'(bus.ADRS), 32'(e.adrs));
          chk("beat_last", 32'(bus.LAST), 32'(e.last));
          if (e.last && !bus.ABORT) done_exp = 1;
        end
        beats++;
      end else if (bus.VALID && !bus.ABORT) begin
        stall_pend = 1;
        stall_val  = {bus.SHIFT, bus.ADRS, bus.LAST};
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus2.DONE) done_cnt2++;
      if (bus2.VALID && bus2.READY) begin
        if (sb2.size() == 0) begin
          chk("sb2_underflow", 32'(bus2.SHIFT), 32'h7ff);
        end else begin
          beat_t e;
          e = sb2.pop_front();
          chk("p_beat_shift", 32'(bus2.SHIFT), 32'(e.shift));
          chk("p_beat_adrs", 32'(bus2.ADRS), 32'(e.adrs));
          chk("p_beat_last", 32'(bus2.LAST), 32'(e.last));
        end
        beats2++;
      end
    end
  end

  task automatic push_full();
    for (int i = 0; i < 26; i++) sb.push_back(mk(full_seq[i], i == 25));
  endtask

  // Called at posedge+1; returns at posedge+1 with the first beat presented.
  task automatic start_pulse();
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    chk("start_latency_valid", 32'(bus.VALID), 32'd1);
    chk("start_busy", 32'(bus.BUSY), 32'd1);
  endtask

  // mode 0: READY=1; mode 1: fixed pattern plus 3-cycle stall on first SHIFT=4;
  // mode 2: READY=1 with a stray START at step 10.
  task automatic drive_run(input int mode, input int budget);
    int          cyc = 0;
    int          stall = 0;
    int          idx = 0;
    bit          stalled4 = 0;
    bit          restarted = 0;
    logic [15:0] pat = 16'hB6E5;
    while (cyc < budget && !(sb.size() == 0 && !bus.BUSY)) begin
      bus.START = 1'b0;
      case (mode)
        1: begin
          if (bus.VALID && bus.SHIFT == 5'd4 && !stalled4) begin
            stalled4 = 1;
            stall    = 3;
          end
          if (stall > 0) begin
            bus.READY = 1'b0;
            stall--;
          end else begin
            bus.READY = pat[idx % 16];
            idx++;
          end
        end
        2: begin
          bus.READY = 1'b1;
          if (beats == 10 && !restarted) begin
            bus.START = 1'b1;
            restarted = 1;
          end
        end
        default: bus.READY = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    bus.START = 1'b0;
    bus.READY = 1'b0;
    if (cyc >= budget) chk("run_timeout", 32'(cyc), 32'(budget - 1));
  endtask

  task automatic full_run(input int mode, input string tag);
    int d0;
    d0    = done_cnt;
    beats = 0;
    push_full();
    start_pulse();
    drive_run(mode, 400);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_beats"}, 32'(beats), 32'd26);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_idle_valid"}, 32'(bus.VALID), 32'd0);
  endtask

  initial begin
    int d0;
    int cyc;
    rst_n      = 1'b1;
    bus.START  = 1'b0;
    bus.ABORT  = 1'b0;
    bus.READY  = 1'b0;
    bus2.START = 1'b0;
    bus2.ABORT = 1'b0;
    bus2.READY = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    chk("rst_shift", 32'(bus.SHIFT), 32'd0);
    chk("rst_adrs", 32'(bus.ADRS), 32'd0);
    chk("rst_last", 32'(bus.LAST), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    full_run(0, "ready_hi");
    full_run(1, "ready_pat");
    full_run(2, "restart_ignored");

    // Abort while SHIFT=6 is presented (beats 1,2,3,4,4,5 already taken).
    d0    = done_cnt;
    beats = 0;
    for (int i = 0; i < 6; i++) sb.push_back(mk(full_seq[i], 1'b0));
    start_pulse();
    bus.READY = 1'b1;
    cyc = 0;
    while (!(bus.VALID && bus.SHIFT == 5'd6) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.READY = 1'b0;
    chk("abort_reach_shift6", 32'(bus.SHIFT), 32'd6);
    @(posedge clk); #1;
    bus.ABORT = 1'b1;
    @(posedge clk); #1;
    bus.ABORT = 1'b0;
    chk("abort_valid", 32'(bus.VALID), 32'd0);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_done", 32'(bus.DONE), 32'd0);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    full_run(0, "after_abort");

    // Asynchronous reset while step 15 is presented.
    d0    = done_cnt;
    beats = 0;
    push_full();
    start_pulse();
    bus.READY = 1'b1;
    cyc = 0;
    while (beats < 15 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid_reach_step15", 32'(beats), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.VALID), 32'd0);
    chk("rst_mid_shift", 32'(bus.SHIFT), 32'd0);
    chk("rst_mid_adrs", 32'(bus.ADRS), 32'd0);
    chk("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_mid_last", 32'(bus.LAST), 32'd0);
    bus.READY  = 1'b0;
    sb.delete();
    stall_pend = 0;
    done_exp   = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;
    full_run(0, "after_reset");

    // Short build: NUM_STEPS=6, REPEAT_B disabled.
    for (int i = 0; i < 6; i++) sb2.push_back(mk(short_seq[i], i == 5));
    beats2     = 0;
    bus2.START = 1'b1;
    @(posedge clk); #1;
    bus2.START = 1'b0;
    bus2.READY = 1'b1;
    cyc = 0;
    while (!(sb2.size() == 0 && !bus2.BUSY) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus2.READY = 1'b0;
    if (cyc >= 60) chk("p_timeout", 32'(cyc), 32'd59);
    chk("p_beats", 32'(beats2), 32'd6);
    chk("p_done_pulses", 32'(done_cnt2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_shift_seq.md
Name: lut_shift_seq

Overview:
- Parametrised successor to the LUT_SHIFT table for the natural-logarithm unit.
- Replaces the address-driven shift ROM with a self-sequencing generator for hyperbolic CORDIC.
- After a START pulse it emits the per-iteration shift amount, including the mandatory repeated iterations (default 4 and 13), over a valid/ready handshake.
- Sits between the LN control FSM and the CORDIC datapath/atanh ROM, and also supplies the ROM address.

Parameters:
- SHIFT_WIDTH, 5: width of SHIFT and ADRS outputs.
- NUM_STEPS, 26: total iterations emitted, repeats included.
- FIRST_SHIFT, 1: shift value of step 0.
- REPEAT_A, 4: first shift value emitted twice.
- REPEAT_B, 13: second shift value emitted twice; set it to 0 to disable.
- Constraint: FIRST_SHIFT+NUM_STEPS < 2^SHIFT_WIDTH. This is checked by elaboration assertion.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- ABORT  in  1  synchronous cancel; returns the block to IDLE.
- READY  in  1  datapath accepts the current step.
- VALID  out  1  SHIFT/ADRS/LAST hold a valid step.
- SHIFT  out  SHIFT_WIDTH  right-shift amount for the current iteration.
- ADRS  out  SHIFT_WIDTH  atanh ROM address; equals SHIFT-1.
- LAST  out  1  current step is step NUM_STEPS-1.
- BUSY  out  1  high in RUN and DONE.
- DONE  out  1  one-cycle pulse after the last step transfers.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, VALID=0, SHIFT=0, ADRS=0, LAST=0, BUSY=0, DONE=0. Internal STEP=0, REP=0.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - START=1 and ABORT=0 -> next cycle RUN, VALID=1, SHIFT=FIRST_SHIFT, STEP=0, REP=0.
  - Latency is 1 cycle from START to the first VALID.
- RUN:
  - Transfer occurs when VALID&READY are high on a clock edge.
  - Without a transfer, SHIFT, ADRS, LAST and VALID hold stable. VALID never drops without a transfer, except on ABORT.
  - On a transfer, if SHIFT is REPEAT_A or REPEAT_B and REP=0: SHIFT holds and REP is set to 1.
  - On any other transfer: SHIFT increments by 1 and REP is cleared to 0.
  - STEP increments on every transfer.
  - LAST = (STEP==NUM_STEPS-1) & VALID.
  - A transfer with LAST=1 -> DONE state; VALID=0 and LAST=0 next cycle.
- DONE: DONE=1 for exactly one cycle, then IDLE. SHIFT keeps its last value until the next START.
- START in RUN or DONE is ignored and not queued.
- ABORT has priority over everything except reset.
  - In any state it causes next cycle IDLE, with VALID=0, DONE=0 and STEP/REP cleared.
  - ABORT and START in the same IDLE cycle: ABORT wins and no sequence starts.
- ABORT in RUN coincident with the last transfer: ABORT wins and no DONE pulse is produced.
- Reset mid-sequence: outputs go to their reset values immediately, with no DONE pulse.
- ADRS = SHIFT-1 is registered alongside SHIFT. In IDLE after reset, ADRS=0.
- All arithmetic is unsigned modulo 2^SHIFT_WIDTH. The parameter constraint prevents wrap.

Test Plan:
- Reset, START pulse, READY tied to 1: VALID rises 1 cycle after START. SHIFT sequence is 1,2,3,4,4,5,...,13,13,14,...,24 (26 beats). ADRS is always SHIFT-1. LAST is asserted only on the beat with SHIFT=24. DONE pulses once, the cycle after that beat.
- READY toggled with a pseudo-random pattern (e.g. 0 for 3 cycles at SHIFT=4, first copy): SHIFT holds 4 and REP does not advance while stalled. The emitted sequence is still identical to the previous scenario.
- START re-pulsed at step 10 while in RUN: the sequence is unaffected, and exactly 26 beats and 1 DONE result.
- ABORT at step 7 (SHIFT=6): next cycle VALID=0, BUSY=0, no DONE. A fresh START restarts at SHIFT=1.
- RST_N low asynchronously mid-cycle during step 15: outputs clear without waiting for a clock edge. After release and START, the first beat is SHIFT=1.
- Parameter override REPEAT_B=0, NUM_STEPS=6: sequence is 1,2,3,4,4,5, with LAST on SHIFT=5.
